seq_alu_mdu: RTL

- Parametrised, registered successor to the single-cycle datapath ALU. Adds RV32M multiply/divide and a start/busy/done handshake.
- Base ops complete in 1 cycle. MUL/DIV ops run iteratively: 1 setup cycle, WIDTH iteration cycles, 1 finalise cycle.
- Sits in the execute stage of the multi-cycle core. The control FSM stalls on busy.

---
 rtl/seq_alu_mdu.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seq_alu_mdu.sv
// -----------------------------------------------------------------------------
// seq_alu_mdu
// Registered execute-stage ALU with an iterative RV32M multiply/divide unit.
// Base ops finish at the sampling edge (done in the following cycle).
// MUL/DIV ops run one setup cycle, WIDTH iteration cycles and one finalise
// cycle. The core's control FSM stalls on busy.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-low reset
//   start   in   op request, sampled only while busy=0
//   flush   in   synchronous abort of the in-flight op (wins over start)
//   op      in   [4:0] operation select
//   a, b    in   [WIDTH-1:0] operands
//   busy    out  op in flight, start ignored
//   done    out  one-cycle pulse, result/zero/cout valid
//   result  out  [WIDTH-1:0] registered result, held until the next done
//   zero    out  registered (result == 0)
//   cout    out  registered carry-out of a + ~b + 1 for the captured operands
// -----------------------------------------------------------------------------
module seq_alu_mdu #(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             flush,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout
);

   localparam logic [4:0] OP_ADD    = 5'd0;
   localparam logic [4:0] OP_SUB    = 5'd1;
   localparam logic [4:0] OP_AND    = 5'd2;
   localparam logic [4:0] OP_OR     = 5'd3;
   localparam logic [4:0] OP_SLL    = 5'd4;
   localparam logic [4:0] OP_SLT    = 5'd5;
   localparam logic [4:0] OP_XOR    = 5'd6;
   localparam logic [4:0] OP_SRL    = 5'd7;
   localparam logic [4:0] OP_SRA    = 5'd8;
   localparam logic [4:0] OP_SLTU   = 5'd9;
   localparam logic [4:0] OP_MUL    = 5'd10;
   localparam logic [4:0] OP_MULH   = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12;
   localparam logic [4:0] OP_MULHU  = 5'd13;
   localparam logic [4:0] OP_DIV    = 5'd14;
   localparam logic [4:0] OP_DIVU   = 5'd15;
   localparam logic [4:0] OP_REM    = 5'd16;
   localparam logic [4:0] OP_REMU   = 5'd17;

   localparam logic [SHW-1:0]   CNT_LAST = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Two's-complement sign correction helpers used at finalise.
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x,
                                                 input logic n);
      return n ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x,
                                                    input logic n);
      return n ? (~x + 1'b1) : x;
   endfunction

   state_t               state_q;
   logic                 busy_q;
   logic                 done_q;
   logic [WIDTH-1:0]     result_q;
   logic                 zero_q;
   logic                 cout_q;
   logic [4:0]           op_q;
   logic                 neg_q;
   logic                 special_q;
   logic                 cout_cap_q;
   logic [SHW-1:0]       cnt_q;
   // MUL: {partial high, multiplier/low product}. DIV: {remainder, dividend/quotient}.
   logic [2*WIDTH-1:0]   prod_q;
   logic [WIDTH-1:0]     mcand_q;

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;
   assign zero   = zero_q;
   assign cout   = cout_q;

   // ---- stage: operand decode / base ops (combinational from inputs) ----
   logic signed [WIDTH-1:0] a_s;
   logic signed [WIDTH-1:0] b_s;
   logic [SHW-1:0]          sh;
   logic [WIDTH:0]          sub_full;
   logic [WIDTH-1:0]        base_res;

   assign a_s      = a;
   assign b_s      = b;
   assign sh       = b[SHW-1:0];
   // Carry-out of a + ~b + 1: set when a >= b unsigned (no borrow).
   assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

   always_comb begin
      base_res = '0;
      case (op)
         OP_ADD:  base_res = a + b;
         OP_SUB:  base_res = a - b;
         OP_AND:  base_res = a & b;
         OP_OR:   base_res = a | b;
         OP_SLL:  base_res = a << sh;
         OP_SLT:  base_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
         OP_XOR:  base_res = a ^ b;
         OP_SRL:  base_res = a >> sh;
         OP_SRA:  base_res = a_s >>> sh;
         OP_SLTU: base_res = {{(WIDTH-1){1'b0}}, (a < b)};
         default: base_res = '0;
      endcase
   end

   logic             is_mul;
   logic             is_div;
   logic             is_rem;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             div0;
   logic             ovf;
   logic [WIDTH-1:0] div_special;

   assign is_mul = (op >= OP_MUL) && (op <= OP_MULHU);
   assign is_div = (op >= OP_DIV) && (op <= OP_REMU);
   assign is_rem = (op == OP_REM) || (op == OP_REMU);
   assign a_neg  = a[WIDTH-1] &
                   ((op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM));
   assign b_neg  = b[WIDTH-1] & ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
   assign a_mag  = cond_neg(a, a_neg);
   assign b_mag  = cond_neg(b, b_neg);
   assign div0   = (b == '0);
   assign ovf    = ((op == OP_DIV) || (op == OP_REM)) && (a == MIN_NEG) && (b == '1);

   // Divide-by-zero and signed overflow bypass the iteration entirely.
   always_comb begin
      div_special = '0;
      if (is_rem)
         div_special = div0 ? a : '0;
      else
         div_special = div0 ? '1 : a;
   end

   // ---- stage: iteration step (combinational from prod_q/mcand_q) ----
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH+1:0]     div_diff;
   logic                 div_ge;
   logic [WIDTH-1:0]     div_rem;
   logic [2*WIDTH-1:0]   div_next;

   assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                     (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
   assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};

   assign div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
   assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
   assign div_ge    = ~div_diff[WIDTH+1];
   // Both candidates are below the divisor, so WIDTH bits always hold the remainder.
   assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_next  = {div_rem, prod_q[WIDTH-2:0], div_ge};

   // ---- stage: finalise (sign correction and half/quotient select) ----
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fin_res;

   assign prod_fix = cond_neg2(prod_q, neg_q);

   always_comb begin
      fin_res = '0;
      if (special_q)
         fin_res = prod_q[WIDTH-1:0];
      else if (op_q == OP_MUL)
         fin_res = prod_fix[WIDTH-1:0];
      else if ((op_q >= OP_MULH) && (op_q <= OP_MULHU))
         fin_res = prod_fix[2*WIDTH-1:WIDTH];
      else if ((op_q == OP_DIV) || (op_q == OP_DIVU))
         fin_res = cond_neg(prod_q[WIDTH-1:0], neg_q);
      else
         fin_res = cond_neg(prod_q[2*WIDTH-1:WIDTH], neg_q);
   end

   // ---- stage: control FSM and output registers ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b1;
         cout_q     <= 1'b0;
         op_q       <= '0;
         neg_q      <= 1'b0;
         special_q  <= 1'b0;
         cout_cap_q <= 1'b0;
         cnt_q      <= '0;
         prod_q     <= '0;
         mcand_q    <= '0;
      end else begin
         done_q <= 1'b0;
         if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     op_q       <= op;
                     cout_cap_q <= sub_full[WIDTH];
                     neg_q      <= is_rem ? a_neg : (a_neg ^ b_neg);
                     cnt_q      <= '0;
                     if (is_mul) begin
                        prod_q    <= {{WIDTH{1'b0}}, b_mag};
                        mcand_q   <= a_mag;
                        special_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= MUL;
                     end else if (is_div) begin
                        mcand_q <= b_mag;
                        busy_q  <= 1'b1;
                        if (div0 || ovf) begin
                           prod_q    <= {{WIDTH{1'b0}}, div_special};
                           special_q <= 1'b1;
                           state_q   <= FIN;
                        end else begin
                           prod_q    <= {{WIDTH{1'b0}}, a_mag};
                           special_q <= 1'b0;
                           state_q   <= DIV;
                        end
                     end else begin
                        result_q <= base_res;
                        zero_q   <= (base_res == '0);
                        cout_q   <= sub_full[WIDTH];
                        done_q   <= 1'b1;
                     end
                  end
               end
               MUL: begin
                  prod_q <= mul_next;
                  cnt_q  <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST)
                     state_q <= FIN;
               end
               DIV: begin
                  prod_q <= div_next;
                  cnt_q  <= cnt_q + 1'b1;
                  if (cnt_q == CNT_LAST)
                     state_q <= FIN;
               end
               FIN: begin
                  result_q <= fin_res;
                  zero_q   <= (fin_res == '0);
                  cout_q   <= cout_cap_q;
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
